// File: rtl/zone_stat.sv
// zone_stat: per-zone max / mean / gray statistics over a raster gray stream.
// Ports: clk, rst_n (async low); pix_valid/pix_sof/pix_gray pixel input;
//        zone_valid/zone_ready handshake with zone_idx, zone_max, zone_mean,
//        zone_gray; frame_done pulse on last zone transfer; sticky overflow.
module zone_stat #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 32,
    parameter int ZONE_W = 16,
    parameter int ZONE_H = 16,
    localparam int ZX = IMG_W / ZONE_W,
    localparam int ZY = IMG_H / ZONE_H,
    localparam int NZ = ZX * ZY,
    localparam int IW = (NZ > 1) ? $clog2(NZ) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_valid,
    input  logic          pix_sof,
    input  logic [7:0]    pix_gray,
    output logic          zone_valid,
    input  logic          zone_ready,
    output logic [IW-1:0] zone_idx,
    output logic [7:0]    zone_max,
    output logic [7:0]    zone_mean,
    output logic [7:0]    zone_gray,
    output logic          frame_done,
    output logic          overflow
);
    localparam int ZA  = $clog2(ZONE_W * ZONE_H);
    localparam int SW  = 8 + ZA;
    localparam int ZB  = $clog2(ZONE_W);
    localparam int ZHB = $clog2(ZONE_H);
    localparam int XW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int CW  = (ZX > 1) ? $clog2(ZX) : 1;

    localparam logic [XW-1:0] XM = XW'(ZONE_W - 1);
    localparam logic [YW-1:0] YM = YW'(ZONE_H - 1);

    typedef enum logic { IN_IDLE, IN_ACTIVE } in_st_t;
    typedef enum logic { O_EMPTY, O_DRAIN } out_st_t;

    in_st_t  in_st;
    out_st_t out_st;

    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [CW-1:0] k_q;

    logic [SW-1:0] acc_sum [ZX];
    logic [7:0]    acc_max [ZX];
    logic [SW-1:0] nxt_sum [ZX];
    logic [7:0]    nxt_max [ZX];
    logic [7:0]    ob_max  [ZX];
    logic [7:0]    ob_mean [ZX];

    logic          take;
    logic [XW-1:0] cur_x;
    logic [YW-1:0] cur_y;
    logic [CW-1:0] col;
    logic          first;
    logic          x_last;
    logic          y_last;
    logic          row_done;
    logic          xfer;
    logic          last_k;
    logic [CW-1:0] kn;
    logic [8:0]    gsum;

    // A start-of-frame pixel is always position (0,0), whatever the FSM state.
    assign take     = pix_valid && (pix_sof || in_st == IN_ACTIVE);
    assign cur_x    = pix_sof ? '0 : x_q;
    assign cur_y    = pix_sof ? '0 : y_q;
    assign col      = CW'(cur_x >> ZB);
    assign first    = ((cur_x & XM) == '0) && ((cur_y & YM) == '0);
    assign x_last   = cur_x == XW'(IMG_W - 1);
    assign y_last   = cur_y == YW'(IMG_H - 1);
    assign row_done = take && x_last && ((cur_y & YM) == YM);

    assign zone_valid = out_st == O_DRAIN;
    assign xfer       = zone_valid && zone_ready;
    assign last_k     = k_q == CW'(ZX - 1);
    assign kn         = k_q + 1'b1;
    assign gsum       = {1'b0, zone_max} + {1'b0, zone_mean};
    assign zone_gray  = gsum[8:1];
    assign frame_done = xfer && zone_idx == IW'(NZ - 1);

    // Next accumulator contents including the current pixel; the first pixel
    // of a zone in a new zone row overwrites the stale entry.
    always_comb begin
        for (int c = 0; c < ZX; c++) begin
            nxt_sum[c] = acc_sum[c];
            nxt_max[c] = acc_max[c];
            if (take && col == CW'(c)) begin
                if (first) begin
                    nxt_sum[c] = SW'(pix_gray);
                    nxt_max[c] = pix_gray;
                end else begin
                    nxt_sum[c] = acc_sum[c] + SW'(pix_gray);
                    if (pix_gray > acc_max[c])
                        nxt_max[c] = pix_gray;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_st     <= IN_IDLE;
            out_st    <= O_EMPTY;
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            zone_idx  <= '0;
            zone_max  <= '0;
            zone_mean <= '0;
            overflow  <= 1'b0;
            for (int c = 0; c < ZX; c++) begin
                acc_sum[c] <= '0;
                acc_max[c] <= '0;
                ob_max[c]  <= '0;
                ob_mean[c] <= '0;
            end
        end else begin
            if (take) begin
                in_st <= IN_ACTIVE;
                for (int c = 0; c < ZX; c++) begin
                    acc_sum[c] <= nxt_sum[c];
                    acc_max[c] <= nxt_max[c];
                end
                if (x_last) begin
                    x_q <= '0;
                    if (y_last) begin
                        y_q   <= '0;
                        in_st <= IN_IDLE;
                    end else begin
                        y_q <= cur_y + 1'b1;
                    end
                end else begin
                    x_q <= cur_x + 1'b1;
                    y_q <= cur_y;
                end
            end

            if (take && pix_sof)
                overflow <= 1'b0;

            // A row load wins over any transfer; it only loses data if the
            // old row still had zones after the one leaving this cycle.
            if (row_done) begin
                for (int c = 0; c < ZX; c++) begin
                    ob_max[c]  <= nxt_max[c];
                    ob_mean[c] <= nxt_sum[c][SW-1 -: 8];
                end
                out_st    <= O_DRAIN;
                k_q       <= '0;
                zone_idx  <= IW'(int'(cur_y >> ZHB) * ZX);
                zone_max  <= nxt_max[0];
                zone_mean <= nxt_sum[0][SW-1 -: 8];
                if (zone_valid && !(xfer && last_k))
                    overflow <= 1'b1;
            end else if (xfer) begin
                if (last_k) begin
                    out_st <= O_EMPTY;
                end else begin
                    k_q       <= kn;
                    zone_idx  <= zone_idx + 1'b1;
                    zone_max  <= ob_max[kn];
                    zone_mean <= ob_mean[kn];
                end
            end
        end
    end
endmodule

// File: tb/tb_zone_stat.sv
// tb_zone_stat: randomized and directed stimulus for zone_stat, checked
// against a frame-buffer reference model with a queue of pending zones.
module tb_zone_stat;
    localparam int W  = 64;
    localparam int H  = 32;
    localparam int ZW = 16;
    localparam int ZH = 16;
    localparam int ZX = W / ZW;
    localparam int NZ = ZX * (H / ZH);

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_valid;
    logic       pix_sof;
    logic [7:0] pix_gray;
    logic       zone_valid;
    logic       zone_ready;
    logic [2:0] zone_idx;
    logic [7:0] zone_max;
    logic [7:0] zone_mean;
    logic [7:0] zone_gray;
    logic       frame_done;
    logic       overflow;

    always #5 clk = ~clk;

    zone_stat dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_valid  (pix_valid),
        .pix_sof    (pix_sof),
        .pix_gray   (pix_gray),
        .zone_valid (zone_valid),
        .zone_ready (zone_ready),
        .zone_idx   (zone_idx),
        .zone_max   (zone_max),
        .zone_mean  (zone_mean),
        .zone_gray  (zone_gray),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    typedef struct {
        int idx;
        int mx;
        int mn;
        int gr;
    } zres_t;

    zres_t pend[$];
    int    fb [H][W];
    int    px, py;
    bit    act, ovf_m;
    int    n_chk, n_pass;

    task automatic chk(string tag, int got, int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        pend.delete();
        ovf_m = 0;
        act   = 0;
        px    = 0;
        py    = 0;
    endtask

    task automatic load_row(int r);
        pend.delete();
        for (int c = 0; c < ZX; c++) begin
            zres_t z;
            int mx, sum;
            mx  = 0;
            sum = 0;
            for (int yy = 0; yy < ZH; yy++)
                for (int xx = 0; xx < ZW; xx++) begin
                    int v;
                    v = fb[r*ZH + yy][c*ZW + xx];
                    sum += v;
                    if (v > mx) mx = v;
                end
            z.idx = r * ZX + c;
            z.mx  = mx;
            z.mn  = sum / (ZW * ZH);
            z.gr  = (z.mx + z.mn) / 2;
            pend.push_back(z);
        end
    endtask

    task automatic step(bit v, bit s, int g, bit rdy);
        bit ev, xf, rd;
        int fd, r;
        pix_valid  = v;
        pix_sof    = s;
        pix_gray   = 8'(g);
        zone_ready = rdy;
        @(negedge clk);
        ev = pend.size() > 0;
        xf = ev && rdy;
        fd = 0;
        rd = 0;
        r  = 0;
        chk("zone_valid", int'(zone_valid), int'(ev));
        chk("overflow", int'(overflow), int'(ovf_m));
        if (xf) fd = (pend[0].idx == NZ - 1) ? 1 : 0;
        chk("frame_done", int'(frame_done), fd);
        if (ev) begin
            chk("zone_idx", int'(zone_idx), pend[0].idx);
            chk("zone_max", int'(zone_max), pend[0].mx);
            chk("zone_mean", int'(zone_mean), pend[0].mn);
            chk("zone_gray", int'(zone_gray), pend[0].gr);
        end
        if (v && (s || act)) begin
            if (s) begin
                px = 0;
                py = 0;
                act = 1;
                ovf_m = 0;
            end
            fb[py][px] = g;
            rd = (px == W - 1) && (py % ZH == ZH - 1);
            r  = py / ZH;
            if (px == W - 1) begin
                px = 0;
                if (py == H - 1) begin
                    py = 0;
                    act = 0;
                end else py++;
            end else px++;
        end
        if (xf) void'(pend.pop_front());
        if (rd) begin
            if (pend.size() > 0) ovf_m = 1;
            load_row(r);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit rdy_of(int m, int i, int n);
        case (m)
            0: return 1'b1;
            1: return 1'b0;
            3: return i >= n - 4;
            default: return $urandom_range(0, 3) != 0;
        endcase
    endfunction

    task automatic pixels(int n, int kind, int val, int rmode, bit gaps);
        for (int i = 0; i < n; i++) begin
            int x, y, g;
            x = i % W;
            y = i / W;
            if (gaps)
                while ($urandom_range(0, 3) == 0)
                    step(0, 1'($urandom_range(0, 1)),
                         int'($urandom_range(0, 255)), rdy_of(rmode, i, n));
            case (kind)
                0: g = val;
                1: g = 4 * x;
                2: g = (x == 17 && y == 20) ? 255 : 0;
                default: g = int'($urandom_range(0, 255));
            endcase
            step(1, i == 0, g, rdy_of(rmode, i, n));
        end
    endtask

    task automatic idle(int n, int rmode);
        for (int i = 0; i < n; i++)
            step(0, 0, 0, rdy_of(rmode, i, n + 8));
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_valid"}, int'(zone_valid), 0);
        chk({tag, "_idx"}, int'(zone_idx), 0);
        chk({tag, "_max"}, int'(zone_max), 0);
        chk({tag, "_mean"}, int'(zone_mean), 0);
        chk({tag, "_gray"}, int'(zone_gray), 0);
        chk({tag, "_fdone"}, int'(frame_done), 0);
        chk({tag, "_ovf"}, int'(overflow), 0);
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        pix_gray = '0;
        zone_ready = 1'b1;
        model_reset();
        #12;
        chk_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        pixels(2048, 0, 100, 0, 0);
        idle(8, 0);
        pixels(2048, 1, 0, 0, 0);
        idle(8, 0);
        pixels(2048, 2, 0, 0, 0);
        idle(8, 0);

        pixels(2048, 0, 77, 1, 0);
        idle(8, 0);
        pixels(2048, 3, 0, 2, 1);
        idle(20, 0);

        pixels(2048, 3, 0, 3, 0);
        idle(8, 0);

        pixels(7 * W + 30, 3, 0, 0, 0);
        pixels(2048, 0, 50, 0, 0);
        idle(8, 0);

        pixels(1024, 0, 90, 0, 0);
        idle(2, 0);
        chk("pre_rst_idx", int'(zone_idx), 2);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 50; i++)
            step(1, 0, int'($urandom_range(0, 255)), 1'b1);
        pixels(2048, 3, 0, 2, 1);
        idle(20, 0);

        for (int f = 0; f < 2; f++) begin
            pixels(2048, 3, 0, 2, 1);
            idle(20, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/zone_stat.md
# zone_stat

Upstream stage of the zonal-backlight log path: takes a raster stream of 8-bit gray pixels and divides the frame into a grid of rectangular zones. For each zone it produces the maximum, the truncated mean and a combined 8-bit zone gray level. Results are emitted in raster zone order over a valid/ready handshake. zone_gray is the value fed to the log stage's 8-bit gray input.

## Interface
- IMG_W, 64, active pixels per line; must be a multiple of ZONE_W
- IMG_H, 32, active lines per frame; must be a multiple of ZONE_H
- ZONE_W, 16, zone width in pixels; power of two
- ZONE_H, 16, zone height in lines; power of two
- Derived values:
  - ZX = IMG_W/ZONE_W
  - ZY = IMG_H/ZONE_H
  - NZ = ZX*ZY
  - SW = 8+log2(ZONE_W*ZONE_H), the accumulator width
  - IW = max(1, clog2(NZ))
- clk  in  1  sole clock; everything samples on the rising edge
- rst_n  in  1  asynchronous active-low reset
- pix_valid  in  1  pixel strobe; one pixel is consumed per cycle it is high; the block never back-pressures pixels
- pix_sof  in  1  qualified by pix_valid; marks pixel (0,0) of a frame
- pix_gray  in  8  pixel gray value
- zone_valid  out  1  a zone result is presented
- zone_ready  in  1  downstream accepts; a transfer happens when valid&&ready
- zone_idx  out  IW  zone number, computed as row*ZX + col
- zone_max  out  8  maximum pixel value in the zone
- zone_mean  out  8  sum >> log2(ZONE_W*ZONE_H), truncated
- zone_gray  out  8  (zone_max + zone_mean) >> 1, computed with a 9-bit intermediate sum
- frame_done  out  1  one-cycle pulse on the transfer of zone NZ-1
- overflow  out  1  sticky error flag; cleared by reset or by the next accepted pix_sof

## Operation
- Input FSM states:
  - IDLE: pixels without pix_sof are ignored.
  - ACTIVE: counting position within a frame.
- Transitions:
  - Any valid pixel with pix_sof enters ACTIVE at x=0, y=0, and that pixel is counted.
  - Accepting pixel (IMG_W-1, IMG_H-1) returns the FSM to IDLE.
- Position counters x and y advance only on pix_valid in ACTIVE; x wraps at IMG_W-1 and increments y.
- Accumulator bank holds ZX entries of {sum[SW], max[8]} for the current zone row.
  - Entry c = x / ZONE_W is updated with sum += gray and max = max(max, gray).
  - The first pixel of a zone row overwrites the entry rather than accumulating (implicit clear).
- Zone-row completion occurs on accepting the pixel at x=IMG_W-1 with y % ZONE_H == ZONE_H-1.
  - All ZX entries, including that final pixel's contribution, are copied into the output buffer.
  - The output counter is set to column 0 of row r = y / ZONE_H.
- Output FSM states:
  - EMPTY: zone_valid=0.
  - DRAIN: zone_valid=1 presenting buffer column k with zone_idx = r*ZX + k. Each transfer advances k; the transfer of k=ZX-1 returns to EMPTY.
- Outputs are stable while zone_valid is high and zone_ready is low.
- Boundary conditions:
  - Zone-row completion while in DRAIN: set overflow, overwrite the buffer with the new row and restart at k=0. The unsent zones of the old row are lost.
  - pix_sof while ACTIVE: the frame is restarted and position resets. The pix_sof pixel begins zone-row 0 with overwrite semantics. The output buffer and any drain in progress are unaffected, and overflow is cleared.
  - pix_sof while IDLE behaves identically, except that no frame is being abandoned.
  - A zone-row completion and a last transfer in the same cycle: the load wins, DRAIN continues at k=0 and no overflow is raised.
  - frame_done pulses only when the transferred zone_idx equals NZ-1.

## Timing
- Reset values: zone_valid=0, zone_idx=0, zone_max=0, zone_mean=0, zone_gray=0, frame_done=0, overflow=0; both FSMs in IDLE/EMPTY; counters 0.
- Latency: zone_valid rises the cycle after the row-completing pixel is accepted.
- Drain rate: with zone_ready held high, the ZX results of a row take ZX consecutive cycles.
- Outputs are registered; zone_gray is derived from registered buffer fields with no extra cycle.
- Deasserting rst_n mid-frame or mid-drain forces the reset values asynchronously. After release, the block waits in IDLE for pix_sof.

## Test plan
- Uniform frame, all pixels 100, ready held high → 8 results, idx 0..7 in order, each max=mean=gray=100. Idx 0..3 appear as 4 consecutive cycles starting 1 cycle after pixel (63,15). frame_done pulses with idx 7.
- Horizontal ramp gray=4*x → for column c in every row: max=64c+60, mean=64c+30, gray=64c+45. Column 3 gives 252/222/237.
- Single pixel (17,20)=255, all other pixels 0 → zone 5 reports max=255, mean=0, gray=127. The other seven zones report 0/0/0.
- zone_ready low from frame start until after pixel (63,31) → overflow=1. Drained results are idx 4..7 only, values intact. The next frame's pix_sof clears overflow.
- pix_sof mid-frame at (30,7), followed by a full frame of value 50 → 8 results of 50. The partial first frame emits nothing.
- rst_n pulsed low during a drain at idx 2 → all outputs 0 immediately. Pixels without pix_sof are ignored afterwards. The next frame is reported correctly.
